if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 115 +++++++++++
 tb/tb_if_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end. It keeps at most one instruction-memory request outstanding
// and feeds a 2-entry {pc, word} buffer whose head drives the decode interface.
module if_fetch_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            flush,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_pop;
    logic             head_q;
    logic             tail;
    logic             pop, push;
    logic [XLEN-1:0]  req_pc_q;
    logic [XLEN-1:0]  buf_pc_q   [DEPTH];
    logic [XLEN-1:0]  buf_word_q [DEPTH];

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    assign count_pop   = count_q - CNT_W'(pop);
    assign tail        = head_q ^ count_q[0];
    assign instr       = buf_word_q[head_q];
    assign instr_pc    = buf_pc_q[head_q];
    assign imem_addr   = imem_req ? pc_addr : '0;

    // Next state, request handshake and buffer push; occupancy is judged after this cycle's pop.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        pc_advance = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && (count_pop < CNT_W'(DEPTH))) state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (flush) begin
                        state_d = DROP;
                    end else begin
                        pc_advance = 1'b1;
                        state_d    = WAIT;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = (count_pop < CNT_W'(DEPTH - 1)) ? REQ : IDLE;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_d = flush ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            head_q   <= 1'b0;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) head_q <= ~head_q;
            if (state_q == REQ && imem_gnt) req_pc_q <= pc_addr;
        end
    end

    // Push only happens at count <= 1, so the tail slot never collides with a live head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_word_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[tail]   <= req_pc_q;
            buf_word_q[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a directed vector table, hand-written corner
// sequences, then random traffic checked against a queue-based reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = '0;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_advance(pc_advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        g, rv;
        logic [31:0] rd;
        logic        fl, rdy;
        logic        e_req, e_adv;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_i, e_p;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    // Reference model: what the unit is doing right now, plus the buffered instructions.
    bit          m_req, m_wait, m_drop;
    logic [31:0] m_pc;
    ent_t        m_q[$];

    function automatic logic [98:0] pk(input logic req, input logic adv, input logic [31:0] addr,
                                       input logic v, input logic [31:0] w, input logic [31:0] p,
                                       input logic care);
        return {req, adv, addr, v, care ? w : 32'h0, care ? p : 32'h0};
    endfunction

    task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/adv/addr/v/instr/pc=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic g, input logic rv,
                         input logic [31:0] rd, input logic fl, input logic rdy);
        pc_addr = pc; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        flush = fl; instr_ready = rdy;
        #1;
    endtask

    task automatic step(input string name, input logic [31:0] pc, input logic g, input logic rv,
                        input logic [31:0] rd, input logic fl, input logic rdy,
                        input logic er, input logic ea, input logic [31:0] eaddr,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        drive(pc, g, rv, rd, fl, rdy);
        chk(name, pk(imem_req, pc_advance, imem_addr, instr_valid, instr, instr_pc, ev),
            pk(er, ea, eaddr, ev, ei, ep, ev));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_req = 0; m_wait = 0; m_drop = 0; m_pc = '0; m_q.delete();
    endtask

    task automatic model_step(input logic [31:0] pc, input logic g, input logic rv,
                              input logic [31:0] rd, input logic fl, input logic rdy);
        bit pop, push;
        int n_after;
        pop     = (m_q.size() > 0) && rdy;
        n_after = m_q.size() - (pop ? 1 : 0);
        push    = 0;
        if (m_req) begin
            if (g) begin
                m_req = 0;
                if (fl) m_drop = 1;
                else begin m_wait = 1; m_pc = pc; end
            end else if (fl) m_req = 0;
        end else if (m_wait) begin
            if (rv) begin
                m_wait = 0;
                if (!fl) begin push = 1; m_req = (n_after + 1 < 2); end
            end else if (fl) begin
                m_wait = 0; m_drop = 1;
            end
        end else if (m_drop) begin
            if (rv) m_drop = 0;
        end else begin
            m_req = !fl && (n_after < 2);
        end
        if (fl) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{pc: m_pc, w: rd});
        end
    endtask

    vec_t tbl[13];

    initial begin
        // Fetch 0x0/0x4 with decode stalled, fill the buffer, pop, then a push+pop at count 1.
        tbl[0]  = '{32'h0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 0, 32'h0,        32'h0};
        tbl[1]  = '{32'h0, 1, 0, 32'h0,        0, 0, 1, 1, 32'h0, 0, 32'h0,        32'h0};
        tbl[2]  = '{32'h4, 0, 1, 32'h00000013, 0, 0, 0, 0, 32'h0, 0, 32'h0,        32'h0};
        tbl[3]  = '{32'h4, 1, 0, 32'h0,        0, 0, 1, 1, 32'h4, 1, 32'h00000013, 32'h0};
        tbl[4]  = '{32'h8, 0, 1, 32'h00400093, 0, 0, 0, 0, 32'h0, 1, 32'h00000013, 32'h0};
        tbl[5]  = '{32'h8, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0, 1, 32'h00000013, 32'h0};
        tbl[6]  = '{32'h8, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0, 1, 32'h00000013, 32'h0};
        tbl[7]  = '{32'h8, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0, 1, 32'h00000013, 32'h0};
        tbl[8]  = '{32'h8, 0, 0, 32'h0,        0, 0, 1, 0, 32'h8, 1, 32'h00400093, 32'h4};
        tbl[9]  = '{32'h8, 1, 0, 32'h0,        0, 0, 1, 1, 32'h8, 1, 32'h00400093, 32'h4};
        tbl[10] = '{32'hC, 0, 1, 32'h00800113, 0, 1, 0, 0, 32'h0, 1, 32'h00400093, 32'h4};
        tbl[11] = '{32'hC, 0, 0, 32'h0,        0, 1, 1, 0, 32'hC, 1, 32'h00800113, 32'h8};
        tbl[12] = '{32'hC, 0, 0, 32'h0,        0, 0, 1, 0, 32'hC, 0, 32'h0,        32'h0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), tbl[i].pc, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].fl,
                 tbl[i].rdy, tbl[i].e_req, tbl[i].e_adv, tbl[i].e_addr, tbl[i].e_v,
                 tbl[i].e_i, tbl[i].e_p);
        end

        // Flush while waiting: the late word is dropped and the redirect target is fetched.
        do_reset();
        step("wflush0", 32'h10,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush1", 32'h10,  1, 0, 32'h0,        0, 0, 1, 1, 32'h10,  0, 32'h0, 32'h0);
        step("wflush2", 32'h14,  0, 0, 32'h0,        1, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush3", 32'h100, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush4", 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush5", 32'h100, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush6", 32'h100, 1, 0, 32'h0,        0, 0, 1, 1, 32'h100, 0, 32'h0, 32'h0);
        step("wflush7", 32'h104, 0, 1, 32'h13,       0, 0, 0, 0, 32'h0,   0, 32'h0, 32'h0);
        step("wflush8", 32'h104, 0, 0, 32'h0,        0, 0, 1, 0, 32'h104, 1, 32'h13, 32'h100);

        // Flush coinciding with grant: no PC advance and the returning word is dropped.
        do_reset();
        step("gflush0", 32'h40, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
        step("gflush1", 32'h40, 1, 0, 32'h0,   1, 0, 1, 0, 32'h40, 0, 32'h0, 32'h0);
        step("gflush2", 32'h40, 0, 1, 32'hBAD, 0, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
        step("gflush3", 32'h40, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
        step("gflush4", 32'h40, 0, 0, 32'h0,   0, 0, 1, 0, 32'h40, 0, 32'h0, 32'h0);

        // Asynchronous reset between edges while waiting, then a stray rvalid after release.
        do_reset();
        step("arst0", 32'h20, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0);
        step("arst1", 32'h20, 1, 0, 32'h0,  0, 0, 1, 1, 32'h20, 0, 32'h0,  32'h0);
        step("arst2", 32'h24, 0, 1, 32'h13, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0);
        step("arst3", 32'h24, 1, 0, 32'h0,  0, 0, 1, 1, 32'h24, 1, 32'h13, 32'h20);
        drive(32'h28, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("arst_pre", pk(imem_req, pc_advance, imem_addr, instr_valid, instr, instr_pc, 1'b1),
            pk(1'b0, 1'b0, 32'h0, 1'b1, 32'h13, 32'h20, 1'b1));
        #2 rst = 1'b1;
        #1;
        chk("arst_now", pk(imem_req, pc_advance, imem_addr, instr_valid, instr, instr_pc, 1'b1),
            pk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("stray0", 32'h28, 0, 1, 32'hBAD, 0, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0);
        step("stray1", 32'h28, 0, 1, 32'hBAD, 0, 0, 1, 0, 32'h28, 0, 32'h0, 32'h0);
        step("stray2", 32'h28, 0, 0, 32'h0,   0, 0, 1, 0, 32'h28, 0, 32'h0, 32'h0);

        // Random traffic against the reference model; the PC follows the expected pc_advance.
        do_reset();
        begin
            logic [31:0] cur_pc, rd;
            logic        g, rv, fl, rdy, e_adv, e_v;
            ent_t        hd;
            cur_pc = 32'h1000;
            for (int c = 0; c < 3000; c++) begin
                fl  = ($urandom_range(0, 19) == 0);
                g   = 1'($urandom_range(0, 1));
                rv  = (m_wait || m_drop) ? 1'($urandom_range(0, 1)) : 1'b0;
                rd  = $urandom;
                rdy = ($urandom_range(0, 2) != 0);
                drive(cur_pc, g, rv, rd, fl, rdy);
                e_adv = m_req && g && !fl;
                e_v   = (m_q.size() > 0);
                hd    = e_v ? m_q[0] : '0;
                chk($sformatf("rand%0d", c),
                    pk(imem_req, pc_advance, imem_addr, instr_valid, instr, instr_pc, e_v),
                    pk(m_req, e_adv, m_req ? cur_pc : 32'h0, e_v, hd.w, hd.pc, e_v));
                model_step(cur_pc, g, rv, rd, fl, rdy);
                if (fl) cur_pc = $urandom & 32'hFFFF_FFFC;
                else if (e_adv) cur_pc = cur_pc + 32'h4;
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
